// File: rtl/stage4_writeback_unit_if.sv
// Stage-4 writeback bus: ALU-stage result/control in; read ports, forward and flags out.
interface stage4_writeback_unit_if;
  logic [7:0] AluOut;
  logic [3:0] flagArray;
  logic       LR0;
  logic       LRN;
  logic [2:0] RNSel;
  logic       FLRN;
  logic       Stall;
  logic       Flush;
  logic [2:0] RdAddrA;
  logic [2:0] RdAddrB;
  logic [7:0] RdDataA;
  logic [7:0] RdDataB;
  logic [7:0] OF;
  logic       Cin;
  logic [3:0] FlagReg;
  logic       WbValid;

  modport master (
    output AluOut, flagArray, LR0, LRN, RNSel, FLRN, Stall, Flush, RdAddrA, RdAddrB,
    input  RdDataA, RdDataB, OF, Cin, FlagReg, WbValid
  );

  modport slave (
    input  AluOut, flagArray, LR0, LRN, RNSel, FLRN, Stall, Flush, RdAddrA, RdAddrB,
    output RdDataA, RdDataB, OF, Cin, FlagReg, WbValid
  );
endinterface

// File: rtl/stage4_writeback_unit.sv
// Pipeline stage 4: latches the ALU result/flags, commits them to the register file and
// flag register on the next non-stall edge, and forwards data/carry back to the ALU.
module stage4_writeback_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input logic                    Clk,
  input logic                    Reset,
  stage4_writeback_unit_if.slave wb
);
  localparam int unsigned DW     = 8;
  localparam int unsigned FW     = 4;
  localparam int unsigned AW     = 3;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned C_BIT  = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [FW-1:0] flags;
    logic [AW-1:0] dst;
    logic          w0;
    logic          wn;
    logic          fl;
  } s4_t;

  s4_t                       s4_q, s4_d;
  logic [NREGS-1:0][DW-1:0]  rf_q, rf_d;
  logic [FW-1:0]             flags_q, flags_d;
  logic                      ce;
  logic                      hit_a, hit_b;

  assign ce = ~wb.Stall;

  // Stage-4 capture; a flush keeps the data but drops every write enable.
  always_comb begin
    s4_d = s4_q;
    if (ce) begin
      s4_d.data  = wb.AluOut;
      s4_d.flags = wb.flagArray;
      s4_d.dst   = wb.RNSel;
      s4_d.w0    = wb.LR0 & ~wb.Flush;
      s4_d.wn    = wb.LRN & ~wb.Flush;
      s4_d.fl    = wb.FLRN & ~wb.Flush;
    end
  end

  // Commit of the outgoing instruction; an RN write to index 0 lands on R0 as well.
  always_comb begin
    rf_d    = rf_q;
    flags_d = flags_q;
    if (ce && s4_q.w0) rf_d[0] = s4_q.data;
    if (ce && s4_q.wn) rf_d[s4_q.dst] = s4_q.data;
    if (ce && s4_q.fl) flags_d = s4_q.flags;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s4_q    <= '0;
      rf_q    <= '0;
      flags_q <= RESET_FLAGS;
    end else begin
      s4_q    <= s4_d;
      rf_q    <= rf_d;
      flags_q <= flags_d;
    end
  end

  // Write-through bypass only while the commit actually happens this cycle.
  assign hit_a = ce & ((s4_q.wn & (s4_q.dst == wb.RdAddrA)) | (s4_q.w0 & (wb.RdAddrA == AW'(0))));
  assign hit_b = ce & ((s4_q.wn & (s4_q.dst == wb.RdAddrB)) | (s4_q.w0 & (wb.RdAddrB == AW'(0))));

  assign wb.RdDataA = hit_a ? s4_q.data : rf_q[wb.RdAddrA];
  assign wb.RdDataB = hit_b ? s4_q.data : rf_q[wb.RdAddrB];
  assign wb.OF      = s4_q.data;
  assign wb.Cin     = s4_q.fl ? s4_q.flags[C_BIT] : flags_q[C_BIT];
  assign wb.FlagReg = flags_q;
  assign wb.WbValid = (s4_q.w0 | s4_q.wn | s4_q.fl) & ce;
endmodule

// File: tb/tb_stage4_writeback_unit.sv
// Scoreboard bench for stage4_writeback_unit: captured instructions queue until commit.
`timescale 1ns/1ps
module tb_stage4_writeback_unit;
  localparam logic [3:0] RST_FLAGS = 4'b1001;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] flags;
    logic [2:0] dst;
    logic       w0;
    logic       wn;
    logic       fl;
  } ins_t;

  logic clk;
  logic rst;
  stage4_writeback_unit_if wb_if ();

  stage4_writeback_unit #(.RESET_FLAGS(RST_FLAGS)) dut (
    .Clk   (clk),
    .Reset (rst),
    .wb    (wb_if.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ins_t       q[$];
  logic [7:0] m_rf [8];
  logic [3:0] m_flags;
  logic [7:0] of_exp;
  logic       of_known;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input logic [7:0] d, input logic [3:0] f, input logic [2:0] dst,
                              input logic w0, input logic wn, input logic fl);
    ins_t i;
    i.data = d; i.flags = f; i.dst = dst; i.w0 = w0; i.wn = wn; i.fl = fl;
    return i;
  endfunction

  function automatic logic [7:0] exp_read(input logic [2:0] a);
    ins_t p;
    if (q.size() != 0 && !wb_if.Stall) begin
      p = q[0];
      if ((p.wn && p.dst == a) || (p.w0 && a == 3'd0)) return p.data;
    end
    return m_rf[a];
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_flags  = RST_FLAGS;
    of_exp   = 8'h00;
    of_known = 1'b1;
  endtask

  task automatic drive(input logic stall, input logic flush, input ins_t ins);
    wb_if.Stall     = stall;
    wb_if.Flush     = flush;
    wb_if.AluOut    = ins.data;
    wb_if.flagArray = ins.flags;
    wb_if.RNSel     = ins.dst;
    wb_if.LR0       = ins.w0;
    wb_if.LRN       = ins.wn;
    wb_if.FLRN      = ins.fl;
  endtask

  // Compare every output against the model for the inputs currently applied.
  task automatic check_outputs();
    ins_t       p;
    logic       has;
    logic [7:0] ea, eb;
    has = (q.size() != 0);
    p   = has ? q[0] : '0;
    if (of_known) check("OF", wb_if.OF, of_exp);
    check("Cin", 8'(wb_if.Cin), 8'((has && p.fl) ? p.flags[2] : m_flags[2]));
    check("FlagReg", 8'(wb_if.FlagReg), 8'(m_flags));
    check("WbValid", 8'(wb_if.WbValid), 8'(has && !wb_if.Stall));
    for (int a = 0; a < 8; a++) begin
      wb_if.RdAddrA = 3'(a);
      wb_if.RdAddrB = 3'(7 - a);
      #1;
      ea = exp_read(3'(a));
      eb = exp_read(3'(7 - a));
      check($sformatf("RdDataA[%0d]", a), wb_if.RdDataA, ea);
      check($sformatf("RdDataB[%0d]", 7 - a), wb_if.RdDataB, eb);
    end
  endtask

  task automatic model_edge(input logic stall, input logic flush, input ins_t ins);
    ins_t p;
    if (!stall) begin
      if (q.size() != 0) begin
        p = q.pop_front();
        if (p.w0) m_rf[0] = p.data;
        if (p.wn) m_rf[p.dst] = p.data;
        if (p.fl) m_flags = p.flags;
      end
      of_exp   = ins.data;
      of_known = !flush;
      if (!flush && (ins.w0 || ins.wn || ins.fl)) q.push_back(ins);
    end
  endtask

  task automatic run_cycle(input logic stall, input logic flush, input ins_t ins);
    drive(stall, flush, ins);
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(stall, flush, ins);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, '0);
  endtask

  // Asynchronous reset asserted and released between edges; outputs must clear at once.
  task automatic pulse_reset();
    drive(1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1 rst = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 1'b0, '0);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ins_t r;
    logic st, fl;
    rst = 1'b1;
    wb_if.RdAddrA = '0;
    wb_if.RdAddrB = '0;
    drive(1'b0, 1'b0, '0);
    model_reset();
    #3;
    check_outputs();
    #4 rst = 1'b0;

    // Basic write: R3 <- 5A with flags 0100
    run_cycle(1'b0, 1'b0, mk(8'h5A, 4'b0100, 3'd3, 1'b0, 1'b1, 1'b1));
    idle(2);

    // Dual write R0/R6, then dual write with RN index 0
    run_cycle(1'b0, 1'b0, mk(8'hC3, 4'b0011, 3'd6, 1'b1, 1'b1, 1'b0));
    idle(1);
    run_cycle(1'b0, 1'b0, mk(8'h77, 4'b1111, 3'd0, 1'b1, 1'b1, 1'b1));
    idle(1);

    // Back-to-back writes to R1: the later one wins
    run_cycle(1'b0, 1'b0, mk(8'hAA, 4'b0000, 3'd1, 1'b0, 1'b1, 1'b0));
    run_cycle(1'b0, 1'b0, mk(8'hBB, 4'b0100, 3'd1, 1'b0, 1'b1, 1'b1));
    idle(1);

    // Stall for three cycles with changing AluOut
    run_cycle(1'b0, 1'b0, mk(8'h11, 4'b0000, 3'd2, 1'b0, 1'b1, 1'b0));
    run_cycle(1'b1, 1'b0, mk(8'h99, 4'b1000, 3'd2, 1'b0, 1'b1, 1'b1));
    run_cycle(1'b1, 1'b0, mk(8'h98, 4'b1000, 3'd7, 1'b1, 1'b1, 1'b1));
    run_cycle(1'b1, 1'b0, mk(8'h97, 4'b1000, 3'd2, 1'b0, 1'b1, 1'b1));
    idle(2);

    // Flush of an R0 write, then flush ignored under stall
    run_cycle(1'b0, 1'b1, mk(8'hFF, 4'b1111, 3'd0, 1'b1, 1'b0, 1'b1));
    idle(1);
    run_cycle(1'b0, 1'b0, mk(8'h44, 4'b0010, 3'd4, 1'b0, 1'b1, 1'b1));
    run_cycle(1'b1, 1'b1, mk(8'hFF, 4'b1111, 3'd0, 1'b1, 1'b0, 1'b0));
    run_cycle(1'b1, 1'b1, mk(8'hFF, 4'b1111, 3'd0, 1'b1, 1'b0, 1'b0));
    run_cycle(1'b0, 1'b1, mk(8'hFF, 4'b1111, 3'd0, 1'b1, 1'b0, 1'b0));
    idle(2);

    // Randomised mix of writes, stalls and flushes
    for (int i = 0; i < 30; i++) begin
      r  = ins_t'($urandom);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 4) == 0);
      run_cycle(st, fl, r);
    end
    idle(2);

    // Reset while an R5 write is pending commit
    run_cycle(1'b0, 1'b0, mk(8'hE7, 4'b1111, 3'd5, 1'b0, 1'b1, 1'b1));
    pulse_reset();
    idle(2);

    // Reset while a held instruction waits out a stall
    run_cycle(1'b0, 1'b0, mk(8'h3C, 4'b0100, 3'd5, 1'b1, 1'b1, 1'b1));
    run_cycle(1'b1, 1'b0, '0);
    pulse_reset();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stage4_writeback_unit.md
# stage4_writeback_unit

Pipeline stage 4 of the 8-bit RISC core. It registers the ALU stage's result and Z/C/S/P flags, then commits them to the 8-entry register file (R0 = accumulator) and the flag register one cycle later. Its stage-4 register drives the operand-forward bus `OF` and the carry input `Cin` back into the ALU stage. It also serves the stage-2 read ports, with write-through bypass.

## Interface
Parameters:
- `RESET_FLAGS`, 4'b0000: flag register value after reset, ordered {Z,C,S,P}.

Ports:
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `AluOut`  in  8  ALU result from stage 3.
- `flagArray`  in  4  ALU flags {Z,C,S,P} (bit3 = Z, bit0 = P).
- `LR0`  in  1  result is written to R0.
- `LRN`  in  1  result is written to RN.
- `RNSel`  in  3  RN index, 0–7; index 0 aliases R0.
- `FLRN`  in  1  flags are loaded from this instruction.
- `Stall`  in  1  hold the stage-4 register and suppress commit.
- `Flush`  in  1  replace the incoming instruction with a bubble.
- `RdAddrA`, `RdAddrB`  in  3  stage-2 read addresses.
- `RdDataA`, `RdDataB`  out  8  read data, with write-through bypass.
- `OF`  out  8  forwarded operand, equal to the stage-4 data register.
- `Cin`  out  1  carry to the ALU, with bypass.
- `FlagReg`  out  4  architectural flags {Z,C,S,P}.
- `WbValid`  out  1  stage 4 holds a committing instruction this cycle.

## Operation
- Stage-4 register fields: `S4Data[7:0]`, `S4Flags[3:0]`, `S4Dst[2:0]`, `S4W0`, `S4WN`, `S4FL`.
- Capture, on an edge with `Stall`=0 and `Flush`=0:
  - `S4Data`←`AluOut`, `S4Flags`←`flagArray`, `S4Dst`←`RNSel`, `S4W0`←`LR0`, `S4WN`←`LRN`, `S4FL`←`FLRN`.
- Flush, on an edge with `Stall`=0 and `Flush`=1:
  - `S4W0`, `S4WN` and `S4FL` are cleared (bubble).
  - Data fields may update and are don't-care.
- Stall=1: the stage-4 register holds and `Flush` is ignored. Upstream keeps `Flush` asserted until the stall ends.
- Commit enable `CE` = ~`Stall`, evaluated on the same edge as capture. The outgoing instruction commits while the next one is captured.
  - If `S4W0` & `CE`: R0 ← `S4Data`.
  - If `S4WN` & `CE`: R[`S4Dst`] ← `S4Data`.
  - If both are set, both registers are written with the same value; with `S4Dst`=0 this is a single write to R0.
  - If `S4FL` & `CE`: `FlagReg` ← `S4Flags`.
- `WbValid` = (`S4W0` | `S4WN` | `S4FL`) & ~`Stall`, combinational.
- Read ports (combinational):
  - `RdDataX` = `S4Data` if the address is being written this cycle, i.e. (`S4WN` & `S4Dst`==addr) | (`S4W0` & addr==0), with `CE`=1.
  - Otherwise `RdDataX` = R[addr].
- `OF` = `S4Data`, unconditionally. The ALU stage decides when to use it.
- `Cin` = `S4Flags[2]` if `S4FL`=1, otherwise `FlagReg[2]`. The bypass applies even under `Stall`.
- No arithmetic is done here; all data is passed through 8 bits wide.

## Timing
- Reset (async assert, sync release) clears:
  - all R0–R7 to 8'h00;
  - `FlagReg` to `RESET_FLAGS`;
  - all `S4*` fields to 0.
- Outputs after reset: `OF`=0, `Cin`=`RESET_FLAGS[2]`, `WbValid`=0, `RdDataA`=`RdDataB`=0.
- Latency:
  - An instruction presented at edge N appears on `OF`/`Cin` after edge N.
  - It is architecturally visible (register file, `FlagReg`) after edge N+1, or after the first non-stall edge thereafter.
  - Stage-2 reads see it from edge N via bypass, once committing.
- Back-to-back writes to the same register: the later write wins; each is committed once.
- Stall for k cycles: no commit happens during the stall and exactly one commit follows.
- Reset mid-stall or mid-commit: the pending instruction is discarded and is not committed.

## Test plan
- **Reset:** assert `Reset` asynchronously mid-cycle.
  - Required: all registers read 00, `FlagReg`=`RESET_FLAGS`, `WbValid`=0, `OF`=00, immediately (before the next edge).
- **Basic write:** `AluOut`=8'h5A, `LRN`=1, `RNSel`=3, `FLRN`=1, `flagArray`=4'b0100.
  - Required: `OF`=5A and `Cin`=1 after edge 1.
  - Required: R3=5A and `FlagReg`=0100 after edge 2.
  - Required: `RdAddrA`=3 returns 5A during the cycle after edge 1 (bypass).
- **Dual write:** `LR0`=`LRN`=1, `RNSel`=6, data 8'hC3.
  - Required: R0=R6=C3 after commit; `RdAddrB`=0 bypasses C3.
- **Stall:** instruction writing R2=8'h11, then `Stall` for 3 cycles with `AluOut` changing.
  - Required: R2 unchanged and `OF`=11 held throughout.
  - Required: R2=11 on the first non-stall edge, committed once.
- **Flush:** `Flush`=1 with `LR0`=1, data 8'hFF.
  - Required: R0 unchanged, `WbValid`=0 next cycle.
  - Required: with `Stall`=1 as well, `Flush` is ignored and the held instruction still commits after the stall.
- **Reset mid-commit:** `Reset` pulse while `S4WN`=1 to R5.
  - Required: R5 stays 00.
